dca_matrix_register_scalar_reader: RTL and testbench
====================================================

Name: dca_matrix_register_scalar_reader

Overview:
- Read-side counterpart of the DCA matrix constant/broadcast registers: takes a full packed matrix and drains it one scalar at a time.
- On an accepted load it snapshots `all_wdata_list2d` into an internal buffer. It then streams the elements out over a valid/ready scalar port, in row-major or column-major (transposed) order.
- Sits between the DCA tensor datapath and scalar consumers such as the store/DMA path and CPU-visible readback.

Parameters:
- MATRIX_SIZE_PARA, 8: matrix is MATRIX_SIZE_PARA x MATRIX_SIZE_PARA.
- BW_TENSOR_SCALAR, 32: bits per scalar element.
- Derived local parameters (from the shared dim includes):
  - MATRIX_NUM_ROW = MATRIX_NUM_COL = MATRIX_SIZE_PARA.
  - BW_TENSOR_ROW = MATRIX_NUM_COL*BW_TENSOR_SCALAR.
  - BW_TENSOR_MATRIX = MATRIX_NUM_ROW*BW_TENSOR_ROW.

Ports:
- clk  input  1  clock.
- rstnn  input  1  reset, asynchronous, active-low.
- load_request  input  1  request to snapshot and stream a matrix.
- load_transpose  input  1  order select, sampled on load accept; 0 = row-major, 1 = column-major.
- all_wdata_list2d  input  BW_TENSOR_MATRIX  source matrix. Element (r,c) is at bits [(r*MATRIX_NUM_COL+c+1)*BW_TENSOR_SCALAR-1 -: BW_TENSOR_SCALAR].
- load_ready  output  1  high in IDLE; a load is accepted when load_request && load_ready.
- scalar_clear  input  1  synchronous abort back to IDLE.
- scalar_rvalid  output  1  scalar_rdata is valid.
- scalar_rready  input  1  consumer accepts the current scalar.
- scalar_rdata  output  BW_TENSOR_SCALAR  current element.
- scalar_rlast  output  1  current element is the final element of the matrix.
- busy  output  1  high in STREAM.

Behaviour:
- Reset values:
  - State IDLE.
  - load_ready = 1.
  - busy = 0.
  - scalar_rvalid = 0.
  - scalar_rlast = 0.
  - scalar_rdata = 0.
  - Buffer, row counter and col counter all 0.
  - Transpose flag = 0.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - load_ready = 1, rvalid = 0.
  - On accept: buffer <= all_wdata_list2d, transpose flag <= load_transpose, row = col = 0, next state STREAM.
- STREAM:
  - rvalid = 1, load_ready = 0, busy = 1.
  - rdata = buffer element (row,col).
- Latency: first rvalid in the cycle after accept.
- Handshake rules:
  - A beat completes on rvalid && rready.
  - rdata and rlast hold stable while rvalid && !rready.
  - rvalid never drops without a handshake, except on clear or reset.
- Index advance on each beat:
  - Row-major: col increments; on col = NUM_COL-1, col wraps to 0 and row increments.
  - Transposed: row increments; on row = NUM_ROW-1, row wraps to 0 and col increments.
- scalar_rlast = rvalid && row = NUM_ROW-1 && col = NUM_COL-1, identical in both orders.
- A beat with rlast moves to IDLE. load_ready = 1 and rvalid = 0 in the next cycle.
- No back-to-back overlap: at least one IDLE cycle between matrices.
- Exactly NUM_ROW*NUM_COL beats per load, with no duplicates or skips.
- load_request while in STREAM is ignored, not queued.
- The snapshot is isolated: changes to all_wdata_list2d after accept do not affect the stream.
- scalar_clear:
  - Takes effect next cycle in any state: state IDLE, counters 0, rvalid 0.
  - Buffer contents are don't-care afterwards.
  - Clear has priority over a same-cycle handshake and over a same-cycle load accept; that load is dropped.
- scalar_rdata is forced to 0 whenever rvalid = 0.
- Asynchronous reset mid-stream returns all outputs to their reset values immediately. No beat completes in that cycle.

Decomposition:
- Shared package/includes: the existing matrix/tensor dim lpara includes supply NUM_ROW, NUM_COL, BW_TENSOR_ROW and BW_TENSOR_MATRIX. Add there:
  - the element-offset helper function (r,c) -> bit offset;
  - the two-state FSM encoding, reused by future readers.
- One natural sub-module: dca_matrix_index_counter.
  - Holds the row/col counters with an order select, advance input, and clear/init input.
  - Outputs row, col and is_last.
- The top level keeps the buffer, FSM and element mux.

Test Plan:
- All tests use N=8, BW=32, element(r,c) = 0x100*r + c.
1. Row-major, rready held 1: load_request for 1 cycle.
   - rvalid rises the next cycle; 64 beats 0x000, 0x001 .. 0x007, 0x100 .. 0x707.
   - rlast only on 0x707; load_ready = 1 the cycle after.
2. Transposed (load_transpose = 1): order is 0x000, 0x100 .. 0x700, 0x001 .. 0x707; rlast only on the 64th beat (0x707).
3. Backpressure: rready follows the pattern 1,0,0,1,0,... (random).
   - rdata and rlast stay stable while stalled; 64 beats, in order, none lost or duplicated.
4. Isolation and busy load:
   - After accept, drive all_wdata_list2d to all 0xFFFFFFFF and pulse load_request at beat 10.
   - The stream is still the original values; exactly 64 beats; no second stream follows.
5. Clear at beat 20 with rready = 1 in the same cycle:
   - Next cycle rvalid = 0, rdata = 0, load_ready = 1.
   - A new load streams from 0x000.
   - Clear and load asserted in the same cycle while IDLE: the load is ignored.
6. Async reset (rstnn low) at beat 30:
   - Outputs immediately show rvalid = 0, rlast = 0, rdata = 0, load_ready = 1, busy = 0.
   - After release, a fresh load streams all 64 beats correctly.

Source files
------------

// File: rtl/dca_matrix_register_scalar_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dca_matrix_register_scalar_reader_pkg
// Brief    : Shared FSM encoding and element-offset helper for matrix readers.
// Revision : 1.0 - initial release
// ============================================================================
package dca_matrix_register_scalar_reader_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } reader_state_e;

  // Bit offset of element (row,col) inside a row-major packed matrix.
  function automatic int elem_offset(input int row, input int col,
                                     input int num_col, input int bw);
    return (row * num_col + col) * bw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dca_matrix_index_counter.sv
`default_nettype none
// ============================================================================
// Module   : dca_matrix_index_counter
// Brief    : Row/col walker over a matrix in row-major or transposed order.
// Revision : 1.0 - initial release
// ============================================================================
module dca_matrix_index_counter #(
  parameter int NUM_ROW = 8,
  parameter int NUM_COL = 8,
  parameter int BW_ROW  = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  parameter int BW_COL  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              init,
  input  logic              advance,
  input  logic              transpose,
  output logic [BW_ROW-1:0] row,
  output logic [BW_COL-1:0] col,
  output logic              is_last
);

  localparam logic [BW_ROW-1:0] c_ROW_LAST = BW_ROW'(NUM_ROW - 1);
  localparam logic [BW_COL-1:0] c_COL_LAST = BW_COL'(NUM_COL - 1);

  logic [BW_ROW-1:0] r_row;
  logic [BW_COL-1:0] r_col;

  // init wins over advance so a clear or fresh load always restarts at (0,0)
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_row <= '0;
      r_col <= '0;
    end else if (init) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance) begin
      if (transpose) begin
        if (r_row == c_ROW_LAST) begin
          r_row <= '0;
          r_col <= (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign row     = r_row;
  assign col     = r_col;
  assign is_last = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

endmodule
`default_nettype wire

// File: rtl/dca_matrix_register_scalar_reader.sv
`default_nettype none
// ============================================================================
// Module   : dca_matrix_register_scalar_reader
// Brief    : Snapshots a packed matrix and drains it over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module dca_matrix_register_scalar_reader
  import dca_matrix_register_scalar_reader_pkg::*;
#(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32
) (
  input  logic                                                        clk,
  input  logic                                                        rstnn,
  input  logic                                                        load_request,
  input  logic                                                        load_transpose,
  input  logic [MATRIX_SIZE_PARA*MATRIX_SIZE_PARA*BW_TENSOR_SCALAR-1:0] all_wdata_list2d,
  output logic                                                        load_ready,
  input  logic                                                        scalar_clear,
  output logic                                                        scalar_rvalid,
  input  logic                                                        scalar_rready,
  output logic [BW_TENSOR_SCALAR-1:0]                                 scalar_rdata,
  output logic                                                        scalar_rlast,
  output logic                                                        busy
);

  localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA;
  localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA;
  localparam int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR;
  localparam int BW_TENSOR_MATRIX = MATRIX_NUM_ROW * BW_TENSOR_ROW;
  localparam int c_BW_ROW         = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1;
  localparam int c_BW_COL         = (MATRIX_NUM_COL > 1) ? $clog2(MATRIX_NUM_COL) : 1;
  localparam int c_BW_OFS         = $clog2(BW_TENSOR_MATRIX);

  reader_state_e               r_state;
  logic [BW_TENSOR_MATRIX-1:0] r_buffer;
  logic                        r_transpose;
  logic [c_BW_ROW-1:0]         w_row;
  logic [c_BW_COL-1:0]         w_col;
  logic                        w_is_last;
  logic                        w_accept;
  logic                        w_beat;
  logic [c_BW_OFS-1:0]         w_offset;

  // Clear outranks both a same-cycle accept and a same-cycle beat
  assign w_accept = (r_state == ST_IDLE) && load_request && !scalar_clear;
  assign w_beat   = (r_state == ST_STREAM) && scalar_rready && !scalar_clear;

  dca_matrix_index_counter #(
    .NUM_ROW (MATRIX_NUM_ROW),
    .NUM_COL (MATRIX_NUM_COL),
    .BW_ROW  (c_BW_ROW),
    .BW_COL  (c_BW_COL)
  ) u_index_counter (
    .clk       (clk),
    .rstnn     (rstnn),
    .init      (scalar_clear || w_accept),
    .advance   (w_beat),
    .transpose (r_transpose),
    .row       (w_row),
    .col       (w_col),
    .is_last   (w_is_last)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state <= ST_IDLE;
    end else if (scalar_clear) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_accept) r_state <= ST_STREAM;
        ST_STREAM: if (w_beat && w_is_last) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_buffer    <= '0;
      r_transpose <= 1'b0;
    end else if (w_accept) begin
      r_buffer    <= all_wdata_list2d;
      r_transpose <= load_transpose;
    end
  end

  assign w_offset = c_BW_OFS'(elem_offset(int'(w_row), int'(w_col),
                                          MATRIX_NUM_COL, BW_TENSOR_SCALAR));

  assign load_ready    = (r_state == ST_IDLE);
  assign busy          = (r_state == ST_STREAM);
  assign scalar_rvalid = (r_state == ST_STREAM);
  assign scalar_rlast  = scalar_rvalid && w_is_last;
  assign scalar_rdata  = scalar_rvalid ? r_buffer[w_offset +: BW_TENSOR_SCALAR] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dca_matrix_register_scalar_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dca_matrix_register_scalar_reader
// Brief    : Directed self-checking bench for the matrix scalar reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dca_matrix_register_scalar_reader;

  localparam int N  = 8;
  localparam int BW = 32;
  localparam int MW = N * N * BW;

  logic          clk = 1'b0;
  logic          rstnn;
  logic          load_request;
  logic          load_transpose;
  logic [MW-1:0] all_wdata_list2d;
  logic          load_ready;
  logic          scalar_clear;
  logic          scalar_rvalid;
  logic          scalar_rready;
  logic [BW-1:0] scalar_rdata;
  logic          scalar_rlast;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] got_data [64];
  logic          got_last [64];
  logic [MW-1:0] ref_matrix;

  always #5 clk = ~clk;

  dca_matrix_register_scalar_reader #(
    .MATRIX_SIZE_PARA (N),
    .BW_TENSOR_SCALAR (BW)
  ) dut (
    .clk              (clk),
    .rstnn            (rstnn),
    .load_request     (load_request),
    .load_transpose   (load_transpose),
    .all_wdata_list2d (all_wdata_list2d),
    .load_ready       (load_ready),
    .scalar_clear     (scalar_clear),
    .scalar_rvalid    (scalar_rvalid),
    .scalar_rready    (scalar_rready),
    .scalar_rdata     (scalar_rdata),
    .scalar_rlast     (scalar_rlast),
    .busy             (busy)
  );

  function automatic logic [BW-1:0] exp_elem(input int k, input bit tr);
    int r, c;
    r = tr ? (k % N) : (k / N);
    c = tr ? (k / N) : (k % N);
    return BW'(32'h100 * r + c);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit tr);
    load_request     = 1'b1;
    load_transpose   = tr;
    all_wdata_list2d = ref_matrix;
    next_cycle();
    load_request     = 1'b0;
    load_transpose   = 1'b0;
  endtask

  // Records completed beats; stops after rlast, max_beats, or cycle budget.
  task automatic collect(input int max_beats, input bit bp, input int req_at,
                         output int n, output int stall_bad, output bit timeout);
    int            cyc;
    bit            stalled, done, req_done;
    logic [BW-1:0] prev_d;
    logic          prev_l;
    n = 0; stall_bad = 0; timeout = 1'b0; cyc = 0;
    stalled = 1'b0; req_done = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (1) begin
      if (stalled && (scalar_rvalid !== 1'b1 || scalar_rdata !== prev_d || scalar_rlast !== prev_l))
        stall_bad++;
      scalar_rready = bp ? ((cyc % 5 == 0) || ($urandom_range(0, 2) == 0)) : 1'b1;
      load_request  = (!req_done && n == req_at);
      if (load_request) req_done = 1'b1;
      stalled = (scalar_rvalid === 1'b1) && !scalar_rready;
      prev_d  = scalar_rdata;
      prev_l  = scalar_rlast;
      done    = 1'b0;
      if (scalar_rvalid === 1'b1 && scalar_rready) begin
        got_data[n] = scalar_rdata;
        got_last[n] = scalar_rlast;
        done = (scalar_rlast === 1'b1);
        n++;
        if (n >= max_beats) done = 1'b1;
      end
      next_cycle();
      load_request = 1'b0;
      cyc++;
      if (done) break;
      if (cyc >= 2000) begin
        timeout = 1'b1;
        break;
      end
    end
    scalar_rready = 1'b0;
  endtask

  task automatic test_reset();
    rstnn = 1'b0; load_request = 1'b0; load_transpose = 1'b0; scalar_clear = 1'b0;
    scalar_rready = 1'b0; all_wdata_list2d = '0;
    #1;
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || scalar_rvalid !== 1'b0 ||
        scalar_rlast !== 1'b0 || scalar_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b rvalid=%b rlast=%b rdata=%h, want 1 0 0 0 0",
               load_ready, busy, scalar_rvalid, scalar_rlast, scalar_rdata);
    end
    repeat (3) next_cycle();
    rstnn = 1'b1;
    next_cycle();
    checks++;
    if (load_ready !== 1'b1 || scalar_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready=%b rvalid=%b, want 1 0", load_ready, scalar_rvalid);
    end
  endtask

  task automatic test_row_major();
    int n, sb; bit to;
    do_load(1'b0);
    checks++;
    if (scalar_rvalid !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_first_valid: got rvalid=%b busy=%b ready=%b, want 1 1 0",
               scalar_rvalid, busy, load_ready);
    end
    collect(64, 1'b0, -1, n, sb, to);
    checks++;
    if (n !== 64 || to) begin
      errors++;
      $display("FAIL rm_beat_count: got %0d beats timeout=%0d, want 64 0", n, to);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_elem(k, 1'b0) || got_last[k] !== (k == 63)) begin
        errors++;
        $display("FAIL rm_beat[%0d]: got data=%h last=%b, want %h %b",
                 k, got_data[k], got_last[k], exp_elem(k, 1'b0), (k == 63));
      end
    end
    checks++;
    if (load_ready !== 1'b1 || scalar_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_idle_after: got ready=%b rvalid=%b busy=%b, want 1 0 0",
               load_ready, scalar_rvalid, busy);
    end
  endtask

  task automatic test_transposed();
    int n, sb; bit to;
    next_cycle();
    do_load(1'b1);
    collect(64, 1'b0, -1, n, sb, to);
    checks++;
    if (n !== 64 || to) begin
      errors++;
      $display("FAIL tr_beat_count: got %0d beats timeout=%0d, want 64 0", n, to);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_elem(k, 1'b1) || got_last[k] !== (k == 63)) begin
        errors++;
        $display("FAIL tr_beat[%0d]: got data=%h last=%b, want %h %b",
                 k, got_data[k], got_last[k], exp_elem(k, 1'b1), (k == 63));
      end
    end
  endtask

  task automatic test_backpressure();
    int n, sb; bit to;
    next_cycle();
    do_load(1'b0);
    collect(64, 1'b1, -1, n, sb, to);
    checks++;
    if (n !== 64 || to || sb !== 0) begin
      errors++;
      $display("FAIL bp_count_stable: got beats=%0d timeout=%0d unstable=%0d, want 64 0 0", n, to, sb);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_elem(k, 1'b0) || got_last[k] !== (k == 63)) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got data=%h last=%b, want %h %b",
                 k, got_data[k], got_last[k], exp_elem(k, 1'b0), (k == 63));
      end
    end
  endtask

  task automatic test_isolation();
    int n, sb; bit to;
    next_cycle();
    do_load(1'b0);
    all_wdata_list2d = '1;
    collect(64, 1'b0, 10, n, sb, to);
    all_wdata_list2d = ref_matrix;
    checks++;
    if (n !== 64 || to) begin
      errors++;
      $display("FAIL iso_beat_count: got %0d beats timeout=%0d, want 64 0", n, to);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_elem(k, 1'b0)) begin
        errors++;
        $display("FAIL iso_beat[%0d]: got %h, want %h", k, got_data[k], exp_elem(k, 1'b0));
      end
    end
    scalar_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (scalar_rvalid !== 1'b0 || load_ready !== 1'b1) begin
        errors++;
        $display("FAIL iso_no_second_stream[%0d]: got rvalid=%b ready=%b, want 0 1",
                 i, scalar_rvalid, load_ready);
      end
      next_cycle();
    end
    scalar_rready = 1'b0;
  endtask

  task automatic test_clear();
    int n, sb; bit to;
    do_load(1'b0);
    collect(20, 1'b0, -1, n, sb, to);
    checks++;
    if (n !== 20 || scalar_rvalid !== 1'b1 || scalar_rdata !== 32'h204) begin
      errors++;
      $display("FAIL clr_pre: got beats=%0d rvalid=%b rdata=%h, want 20 1 00000204",
               n, scalar_rvalid, scalar_rdata);
    end
    scalar_clear  = 1'b1;
    scalar_rready = 1'b1;
    next_cycle();
    scalar_clear  = 1'b0;
    scalar_rready = 1'b0;
    checks++;
    if (scalar_rvalid !== 1'b0 || scalar_rdata !== '0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: got rvalid=%b rdata=%h ready=%b busy=%b, want 0 0 1 0",
               scalar_rvalid, scalar_rdata, load_ready, busy);
    end
    do_load(1'b0);
    collect(64, 1'b0, -1, n, sb, to);
    checks++;
    if (n !== 64 || to) begin
      errors++;
      $display("FAIL clr_reload_count: got %0d beats timeout=%0d, want 64 0", n, to);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_elem(k, 1'b0)) begin
        errors++;
        $display("FAIL clr_reload_beat[%0d]: got %h, want %h", k, got_data[k], exp_elem(k, 1'b0));
      end
    end
    load_request = 1'b1;
    scalar_clear = 1'b1;
    next_cycle();
    load_request = 1'b0;
    scalar_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (scalar_rvalid !== 1'b0 || load_ready !== 1'b1) begin
        errors++;
        $display("FAIL clr_load_dropped[%0d]: got rvalid=%b ready=%b, want 0 1",
                 i, scalar_rvalid, load_ready);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    int n, sb; bit to;
    do_load(1'b1);
    collect(30, 1'b0, -1, n, sb, to);
    scalar_rready = 1'b1;
    rstnn = 1'b0;
    #1;
    checks++;
    if (scalar_rvalid !== 1'b0 || scalar_rlast !== 1'b0 || scalar_rdata !== '0 ||
        load_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs: got rvalid=%b rlast=%b rdata=%h ready=%b busy=%b, want 0 0 0 1 0",
               scalar_rvalid, scalar_rlast, scalar_rdata, load_ready, busy);
    end
    scalar_rready = 1'b0;
    next_cycle();
    rstnn = 1'b1;
    next_cycle();
    do_load(1'b0);
    collect(64, 1'b0, -1, n, sb, to);
    checks++;
    if (n !== 64 || to) begin
      errors++;
      $display("FAIL arst_reload_count: got %0d beats timeout=%0d, want 64 0", n, to);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_elem(k, 1'b0) || got_last[k] !== (k == 63)) begin
        errors++;
        $display("FAIL arst_reload_beat[%0d]: got data=%h last=%b, want %h %b",
                 k, got_data[k], got_last[k], exp_elem(k, 1'b0), (k == 63));
      end
    end
  endtask

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ref_matrix[(r*N + c)*BW +: BW] = BW'(32'h100 * r + c);
    test_reset();
    test_row_major();
    test_transposed();
    test_backpressure();
    test_isolation();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
